// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM-stage data-memory controller.
// Holds the FSM state enum, funct3 access-size codes and the misalignment helper.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int BE_W = 4;

    // Halfwords need a[0]==0, words need a[1:0]==0; bytes are always aligned.
    function automatic logic misaligned(input logic [2:0] f3,
                                        input logic [1:0] off);
        logic [1:0] sz;
        sz = f3[1:0];
        return ((sz == F3_H[1:0]) && off[0]) ||
               ((sz == F3_W[1:0]) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/ack bus between the MEM stage and the data memory.
// master = pipeline side (drives the request), slave = memory side.
interface mem_access_stage_if #(
    parameter int AW = 32
);
    import mem_stage_pkg::*;

    logic                 mem_req_o;
    logic                 mem_we_o;
    logic [AW-1:0]        mem_addr_o;
    logic [31:0]          mem_wdata_o;
    logic [BE_W-1:0]      mem_be_o;
    logic                 mem_ack_i;
    logic [31:0]          mem_rdata_i;

    modport master (
        output mem_req_o,
        output mem_we_o,
        output mem_addr_o,
        output mem_wdata_o,
        output mem_be_o,
        input  mem_ack_i,
        input  mem_rdata_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_we_o,
        input  mem_addr_o,
        input  mem_wdata_o,
        input  mem_be_o,
        output mem_ack_i,
        output mem_rdata_i
    );

endinterface

// File: rtl/mem_load_align.sv
// Load lane select and sign/zero extension for sub-word loads.
// Purely combinational; offset and funct3 come from the latched request.
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = rdata[{off, 3'b000} +: 8];
        lane_h = off[1] ? rdata[31:16] : rdata[15:0];
        data   = rdata;
        unique case (funct3)
            F3_B:    data = {{24{lane_b[7]}}, lane_b};
            F3_BU:   data = {24'h0, lane_b};
            F3_H:    data = {{16{lane_h[15]}}, lane_h};
            F3_HU:   data = {16'h0, lane_h};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM-stage data-memory controller: req/ack to a variable-latency memory, stalls until ack.
// Optional MEM_SUBWORD_EN adds byte/half accesses, lane steering and misalignment errors.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255,
    parameter int AW          = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [2:0]  funct3_i,
    output logic        stall_o,
    output logic        bubble_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    mem_access_stage_if.master mem
);

    localparam int CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
    localparam logic [CW-1:0] LIM = CW'(TIMEOUT_CYC - 1);

    state_t state_q, state_d;

    logic            acc;
    logic            is_st;
    logic            misal;
    logic            start;
    logic            fin_ack;
    logic            tmo;
    logic            mis_err;
    logic            stall;
    logic            bubble;

    logic [CW-1:0]   cnt_q;
    logic            req_q;
    logic            we_q;
    logic [AW-1:0]   addr_q;
    logic [31:0]     wdata_q;
    logic [BE_W-1:0] be_q;
    logic [31:0]     rdata_q;
    logic            err_q;

    logic [BE_W-1:0] st_be;
    logic [31:0]     st_wdata;
    logic [31:0]     ld_data;
    logic            unused_bits;

    assign acc   = MemRead_i | MemWrite_i;
    assign is_st = MemWrite_i;

`ifdef MEM_SUBWORD_EN
    logic [1:0] off_q;
    logic [2:0] f3_q;
    logic       sz_b;
    logic       sz_h;

    assign sz_b  = (funct3_i[1:0] == F3_B[1:0]);
    assign sz_h  = (funct3_i[1:0] == F3_H[1:0]);
    assign misal = misaligned(funct3_i, addr_i[1:0]);

    always_comb begin
        st_be    = 4'hF;
        st_wdata = wdata_i;
        unique case (1'b1)
            sz_b: begin
                st_be    = 4'b0001 << addr_i[1:0];
                st_wdata = {4{wdata_i[7:0]}};
            end
            sz_h: begin
                st_be    = 4'b0011 << addr_i[1:0];
                st_wdata = {2{wdata_i[15:0]}};
            end
            default: begin
                st_be    = 4'hF;
                st_wdata = wdata_i;
            end
        endcase
    end

    mem_load_align u_align (
        .rdata  (mem.mem_rdata_i),
        .off    (off_q),
        .funct3 (f3_q),
        .data   (ld_data)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            off_q <= '0;
            f3_q  <= '0;
        end else if (start) begin
            off_q <= addr_i[1:0];
            f3_q  <= funct3_i;
        end
    end

    assign unused_bits = ^addr_i;
`else
    assign misal       = 1'b0;
    assign st_be       = 4'hF;
    assign st_wdata    = wdata_i;
    assign ld_data     = mem.mem_rdata_i;
    assign unused_bits = ^{funct3_i, addr_i};
`endif

    // The detect cycle is bubbled too, so MEM/WB only ever sees the access once, in DONE.
    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        bubble  = 1'b0;
        start   = 1'b0;
        fin_ack = 1'b0;
        tmo     = 1'b0;
        mis_err = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (acc) begin
                    stall  = 1'b1;
                    bubble = 1'b1;
                    if (misal) begin
                        mis_err = 1'b1;
                        state_d = DONE;
                    end else begin
                        start   = 1'b1;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                stall  = 1'b1;
                bubble = 1'b1;
                if (mem.mem_ack_i) begin
                    fin_ack = 1'b1;
                    state_d = DONE;
                end else if (cnt_q == LIM) begin
                    tmo     = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (start) begin
                cnt_q   <= '0;
                req_q   <= 1'b1;
                we_q    <= is_st;
                addr_q  <= {addr_i[AW-1:2], 2'b00};
                wdata_q <= st_wdata;
                be_q    <= st_be;
            end else if (state_q == REQ) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (fin_ack || tmo) begin
                req_q <= 1'b0;
            end
            if (fin_ack && !we_q) begin
                rdata_q <= ld_data;
            end
            if (tmo && !we_q) begin
                rdata_q <= '0;
            end
            if (tmo || mis_err) begin
                err_q <= 1'b1;
            end
        end
    end

    assign stall_o         = stall & ~rst_i;
    assign bubble_o        = bubble & ~rst_i;
    assign rdata_o         = rdata_q;
    assign err_o           = err_q;
    assign mem.mem_req_o   = req_q;
    assign mem.mem_we_o    = we_q;
    assign mem.mem_addr_o  = addr_q;
    assign mem.mem_wdata_o = wdata_q;
    assign mem.mem_be_o    = be_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage (TIMEOUT_CYC=4).
// Inputs change and outputs are sampled on the falling edge.
module tb_mem_access_stage;
    import mem_stage_pkg::*;

    logic        clk_i;
    logic        rst_i;
    logic        MemRead_i;
    logic        MemWrite_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [2:0]  funct3_i;
    logic        stall_o;
    logic        bubble_o;
    logic [31:0] rdata_o;
    logic        err_o;

    int checks;
    int failures;

    mem_access_stage_if #(.AW(32)) mem ();

    mem_access_stage #(
        .TIMEOUT_CYC (4),
        .AW          (32)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .MemRead_i  (MemRead_i),
        .MemWrite_i (MemWrite_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .funct3_i   (funct3_i),
        .stall_o    (stall_o),
        .bubble_o   (bubble_o),
        .rdata_o    (rdata_o),
        .err_o      (err_o),
        .mem        (mem)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        checks           = 0;
        failures         = 0;
        rst_i            = 1'b1;
        MemRead_i        = 1'b1;
        MemWrite_i       = 1'b0;
        addr_i           = 32'h100;
        wdata_i          = 32'h0;
        funct3_i         = F3_W;
        mem.mem_ack_i    = 1'b0;
        mem.mem_rdata_i  = 32'h0;

        // reset state, with a load pending on the inputs
        repeat (2) @(negedge clk_i);
        chk("rst_stall", stall_o, 0);
        chk("rst_bubble", bubble_o, 0);
        chk("rst_req", mem.mem_req_o, 0);
        chk("rst_we", mem.mem_we_o, 0);
        chk("rst_addr", mem.mem_addr_o, 0);
        chk("rst_wdata", mem.mem_wdata_o, 0);
        chk("rst_be", mem.mem_be_o, 0);
        chk("rst_rdata", rdata_o, 0);
        chk("rst_err", err_o, 0);
        MemRead_i = 1'b0;
        rst_i     = 1'b0;
        @(negedge clk_i);
        chk("idle_nomem_stall", stall_o, 0);

        // 1: LW 0x100, ack on second REQ cycle
        MemRead_i = 1'b1;
        addr_i    = 32'h100;
        funct3_i  = F3_W;
        #1;
        chk("t1_stall_c1", stall_o, 1);
        @(negedge clk_i);
        chk("t1_req", mem.mem_req_o, 1);
        chk("t1_we", mem.mem_we_o, 0);
        chk("t1_addr", mem.mem_addr_o, 32'h100);
        chk("t1_be", mem.mem_be_o, 4'hF);
        chk("t1_stall_c2", stall_o, 1);
        chk("t1_bubble_c2", bubble_o, 1);
        @(negedge clk_i);
        chk("t1_stall_c3", stall_o, 1);
        chk("t1_req_held", mem.mem_req_o, 1);
        mem.mem_ack_i   = 1'b1;
        mem.mem_rdata_i = 32'hDEADBEEF;
        @(negedge clk_i);
        mem.mem_ack_i = 1'b0;
        MemRead_i     = 1'b0;
        chk("t1_done_stall", stall_o, 0);
        chk("t1_done_bubble", bubble_o, 0);
        chk("t1_rdata", rdata_o, 32'hDEADBEEF);
        chk("t1_req_drop", mem.mem_req_o, 0);
        @(negedge clk_i);
        chk("t1_idle_stall", stall_o, 0);

        // 2: SW 0x104, ack on first REQ cycle
        MemWrite_i = 1'b1;
        addr_i     = 32'h104;
        wdata_i    = 32'h12345678;
        funct3_i   = F3_W;
        #1;
        chk("t2_stall_c1", stall_o, 1);
        @(negedge clk_i);
        chk("t2_req", mem.mem_req_o, 1);
        chk("t2_we", mem.mem_we_o, 1);
        chk("t2_addr", mem.mem_addr_o, 32'h104);
        chk("t2_wdata", mem.mem_wdata_o, 32'h12345678);
        chk("t2_be", mem.mem_be_o, 4'hF);
        chk("t2_stall_c2", stall_o, 1);
        mem.mem_ack_i   = 1'b1;
        mem.mem_rdata_i = 32'h55555555;
        @(negedge clk_i);
        mem.mem_ack_i = 1'b0;
        MemWrite_i    = 1'b0;
        chk("t2_done_stall", stall_o, 0);
        chk("t2_rdata_kept", rdata_o, 32'hDEADBEEF);
        chk("t2_req_drop", mem.mem_req_o, 0);
        @(negedge clk_i);

        // stray ack while idle
        mem.mem_ack_i   = 1'b1;
        mem.mem_rdata_i = 32'h11111111;
        @(negedge clk_i);
        mem.mem_ack_i = 1'b0;
        chk("stray_rdata", rdata_o, 32'hDEADBEEF);
        chk("stray_req", mem.mem_req_o, 0);
        chk("stray_stall", stall_o, 0);

        // 4: load never acked, timeout after 4 REQ cycles
        MemRead_i = 1'b1;
        addr_i    = 32'h200;
        funct3_i  = F3_W;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            chk($sformatf("t4_req_c%0d", i), mem.mem_req_o, 1);
            chk($sformatf("t4_err_c%0d", i), err_o, 0);
        end
        @(negedge clk_i);
        MemRead_i = 1'b0;
        chk("t4_err", err_o, 1);
        chk("t4_req_drop", mem.mem_req_o, 0);
        chk("t4_stall", stall_o, 0);
        chk("t4_rdata", rdata_o, 0);
        @(negedge clk_i);
        chk("t4_err_sticky", err_o, 1);

        // 5: reset in the middle of REQ, late ack ignored
        MemRead_i = 1'b1;
        addr_i    = 32'h300;
        @(negedge clk_i);
        chk("t5_req", mem.mem_req_o, 1);
        #2;
        rst_i     = 1'b1;
        MemRead_i = 1'b0;
        #1;
        chk("t5_rst_req", mem.mem_req_o, 0);
        chk("t5_rst_stall", stall_o, 0);
        chk("t5_rst_bubble", bubble_o, 0);
        chk("t5_rst_err", err_o, 0);
        chk("t5_rst_rdata", rdata_o, 0);
        chk("t5_rst_addr", mem.mem_addr_o, 0);
        @(negedge clk_i);
        rst_i           = 1'b0;
        mem.mem_ack_i   = 1'b1;
        mem.mem_rdata_i = 32'hCAFEF00D;
        @(negedge clk_i);
        mem.mem_ack_i = 1'b0;
        chk("t5_late_rdata", rdata_o, 0);
        chk("t5_late_req", mem.mem_req_o, 0);
        chk("t5_late_stall", stall_o, 0);
        MemRead_i = 1'b1;
        addr_i    = 32'h300;
        @(negedge clk_i);
        chk("t5_next_req", mem.mem_req_o, 1);
        chk("t5_next_addr", mem.mem_addr_o, 32'h300);
        mem.mem_ack_i   = 1'b1;
        mem.mem_rdata_i = 32'h0BADC0DE;
        @(negedge clk_i);
        mem.mem_ack_i = 1'b0;
        MemRead_i     = 1'b0;
        chk("t5_next_rdata", rdata_o, 32'h0BADC0DE);
        chk("t5_next_stall", stall_o, 0);
        chk("t5_next_err", err_o, 0);
        @(negedge clk_i);

`ifdef MEM_SUBWORD_EN
        // 3: LB / LBU at 0x103, SH at 0x102
        MemRead_i = 1'b1;
        addr_i    = 32'h103;
        funct3_i  = F3_B;
        @(negedge clk_i);
        chk("t3_lb_addr", mem.mem_addr_o, 32'h100);
        mem.mem_ack_i   = 1'b1;
        mem.mem_rdata_i = 32'h80FFFFFF;
        @(negedge clk_i);
        mem.mem_ack_i = 1'b0;
        MemRead_i     = 1'b0;
        chk("t3_lb_rdata", rdata_o, 32'hFFFFFF80);
        @(negedge clk_i);
        MemRead_i = 1'b1;
        funct3_i  = F3_BU;
        @(negedge clk_i);
        mem.mem_ack_i = 1'b1;
        @(negedge clk_i);
        mem.mem_ack_i = 1'b0;
        MemRead_i     = 1'b0;
        chk("t3_lbu_rdata", rdata_o, 32'h00000080);
        @(negedge clk_i);
        MemWrite_i = 1'b1;
        addr_i     = 32'h102;
        wdata_i    = 32'h0000ABCD;
        funct3_i   = F3_H;
        @(negedge clk_i);
        chk("t3_sh_be", mem.mem_be_o, 4'b1100);
        chk("t3_sh_wdata", mem.mem_wdata_o, 32'hABCDABCD);
        chk("t3_sh_addr", mem.mem_addr_o, 32'h100);
        chk("t3_sh_we", mem.mem_we_o, 1);
        mem.mem_ack_i = 1'b1;
        @(negedge clk_i);
        mem.mem_ack_i = 1'b0;
        MemWrite_i    = 1'b0;
        chk("t3_sh_rdata_kept", rdata_o, 32'h00000080);
        @(negedge clk_i);

        // 6: misaligned LW, no request, one stall cycle
        chk("t6_err_before", err_o, 0);
        MemRead_i = 1'b1;
        addr_i    = 32'h102;
        funct3_i  = F3_W;
        #1;
        chk("t6_stall_c1", stall_o, 1);
        @(negedge clk_i);
        MemRead_i = 1'b0;
        chk("t6_req", mem.mem_req_o, 0);
        chk("t6_err", err_o, 1);
        chk("t6_stall_done", stall_o, 0);
        @(negedge clk_i);
        chk("t6_req_idle", mem.mem_req_o, 0);
        chk("t6_stall_idle", stall_o, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
